riscv_muldiv: RTL and testbench
===============================

RISCV_MULDIV -- requirements
Module: riscv_muldiv

Interface
REQ-001 Parameter XLEN, default 32: operand and result width; SHALL support any even value 8..64.
REQ-002 Parameter EARLY_OUT, default 1: when 1, divide-by-zero and signed-overflow cases take the 1-cycle fast path; when 0, they take full latency.
REQ-003 Port clk, input, 1: single clock; all state SHALL update on rising edge.
REQ-004 Port rst_n, input, 1: synchronous, active-low reset.
REQ-005 Port valid_i, input, 1: request valid.
REQ-006 Port ready_o, output, 1: unit can accept a request.
REQ-007 Port funct3_i, input, 3: M-extension op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-008 Port op_a_i, input, XLEN: rs1 operand (multiplicand / dividend).
REQ-009 Port op_b_i, input, XLEN: rs2 operand (multiplier / divisor).
REQ-010 Port flush_i, input, 1: abort in-flight operation (pipeline flush).
REQ-011 Port valid_o, output, 1: result valid.
REQ-012 Port ready_i, input, 1: consumer accepts the result.
REQ-013 Port result_o, output, XLEN: operation result.
REQ-014 Port busy_o, output, 1: high in CALC or DONE.

Function
REQ-015 The unit SHALL accept a request on any cycle where valid_i && ready_o; ready_o SHALL be high only in IDLE.
REQ-016 The FSM SHALL have states IDLE, CALC and DONE: IDLE->CALC on accept; CALC->DONE when the iteration counter reaches XLEN; DONE->IDLE on valid_o && ready_i.
REQ-017 The unit SHALL latch funct3, operands and derived sign flags on accept; inputs SHALL be ignored outside the accept cycle.
REQ-018 Multiply SHALL use radix-2 shift-add over the operand magnitudes for XLEN iterations, forming a 2*XLEN product.
REQ-019 Operand signedness SHALL be: MUL/MULH/DIV/REM both signed; MULHSU op_a signed and op_b unsigned; MULHU/DIVU/REMU both unsigned.
REQ-020 The product SHALL be negated when exactly one signed operand is negative.
REQ-021 MUL SHALL return product[XLEN-1:0]; MULH/MULHSU/MULHU SHALL return product[2*XLEN-1:XLEN].
REQ-022 Divide SHALL be restoring, one quotient bit per cycle over magnitudes for XLEN iterations.
REQ-023 The signed quotient SHALL be negated iff operand signs differ; the remainder SHALL take the dividend's sign.
REQ-024 Divisor zero SHALL yield quotient all-ones and remainder equal to op_a.
REQ-025 Signed DIV/REM of the most negative value by -1 SHALL yield quotient equal to op_a and remainder 0.
REQ-026 Normal latency: an accept in cycle N SHALL give valid_o high from cycle N+XLEN+1.
REQ-027 With EARLY_OUT=1, the REQ-024/REQ-025 cases SHALL go IDLE->DONE with valid_o high in cycle N+1.
REQ-028 In DONE, valid_o SHALL be high and result_o stable until ready_i; a new request SHALL NOT be accepted in the handshake cycle (ready_o rises the cycle after).
REQ-029 flush_i SHALL have priority over all transitions: from CALC or DONE the FSM SHALL go to IDLE next cycle with valid_o low; flush_i with valid_i in IDLE SHALL drop the request.
REQ-030 The iteration counter SHALL be $clog2(XLEN)+1 bits and SHALL clear on accept and on flush.
REQ-031 result_o SHALL be 0 whenever valid_o is low.

Reset
REQ-032 While rst_n is low at a clock edge, the FSM SHALL go to IDLE and the counter and all datapath registers SHALL clear.
REQ-033 After reset, outputs SHALL be ready_o=1, valid_o=0, busy_o=0 and result_o=0.
REQ-034 Reset asserted mid-CALC or in DONE SHALL abort the operation with no valid_o pulse.

Verification (XLEN=32, EARLY_OUT=1)
REQ-035 MUL 7 x 0xFFFFFFFD accepted at cycle N SHALL give result_o=0xFFFFFFEB with valid_o first high at N+33.
REQ-036 MULH 0x80000000 x 0x80000000 SHALL give 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF SHALL give 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF SHALL give 0xFFFFFFFF.
REQ-037 DIV 0xFFFFFFF9 / 2 SHALL give 0xFFFFFFFD, and REM with the same operands SHALL give 0xFFFFFFFF; DIVU 100 / 7 SHALL give 14, and REMU with the same operands SHALL give 2.
REQ-038 DIVU 5 / 0 SHALL give 0xFFFFFFFF and REMU 5 / 0 SHALL give 5; DIV 0x80000000 / 0xFFFFFFFF SHALL give 0x80000000 and REM with the same operands SHALL give 0; in each case valid_o SHALL be high at N+1.
REQ-039 With ready_i held low for 5 cycles in DONE, valid_o SHALL stay high and result_o stable with ready_o low; on ready_i high, ready_o SHALL be 1 the next cycle and back-to-back requests SHALL complete correctly.
REQ-040 flush_i at N+10 of a DIV, and separately rst_n low at N+20, SHALL produce no valid_o and ready_o=1 on the following cycle; a subsequent MUL 3 x 4 SHALL give 12.

Source files
------------

// File: rtl/riscv_muldiv.sv
// Iterative RV32/64 M-extension unit: radix-2 shift-add multiply and restoring
// divide over operand magnitudes, with sign fix-up applied combinationally in DONE.
module riscv_muldiv #(
  parameter int XLEN      = 32,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  input  logic            flush_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o
);
  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;
  state_t r_state, w_next;

  logic [2:0]        r_f3;
  logic [XLEN-1:0]   r_a, r_b, r_hi, r_lo;
  logic              r_sa, r_neg, r_dz, r_ovf;
  logic [CW-1:0]     r_cnt;

  logic              w_accept, w_sa, w_sb, w_dz, w_ovf, w_ge;
  logic [XLEN-1:0]   w_mag_a, w_mag_b, w_quo, w_rem, w_res;
  logic [XLEN:0]     w_sum, w_shr, w_sub;
  logic [2*XLEN-1:0] w_prod;

  assign w_accept = valid_i && ready_o && !flush_i;

  // Effective sign: operand MSB gated by whether this op treats it as signed.
  assign w_sa = op_a_i[XLEN-1] & (funct3_i[2] ? ~funct3_i[0] : (funct3_i[1:0] != 2'b11));
  assign w_sb = op_b_i[XLEN-1] & (funct3_i[2] ? ~funct3_i[0] : ~funct3_i[1]);
  assign w_mag_a = w_sa ? -op_a_i : op_a_i;
  assign w_mag_b = w_sb ? -op_b_i : op_b_i;
  assign w_dz  = funct3_i[2] && (op_b_i == '0);
  assign w_ovf = funct3_i[2] && !funct3_i[0] && (op_a_i == {1'b1, {(XLEN-1){1'b0}}})
                 && (op_b_i == '1);

  // Multiply step: {hi,lo} shifts right, lo[0] selects adding the multiplicand.
  assign w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
  // Divide step: remainder picks up the next dividend bit, subtract if it fits.
  assign w_shr = {r_hi, r_lo[XLEN-1]};
  assign w_ge  = (w_shr >= {1'b0, r_b});
  assign w_sub = w_shr - {1'b0, r_b};

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = (EARLY_OUT && (w_dz || w_ovf)) ? S_DONE : S_CALC;
      S_CALC: if (r_cnt == LAST) w_next = S_DONE;
      S_DONE: if (ready_i) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (flush_i) w_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_f3    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_sa    <= 1'b0;
      r_neg   <= 1'b0;
      r_dz    <= 1'b0;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (flush_i) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_f3  <= funct3_i;
        r_a   <= op_a_i;
        r_b   <= w_mag_b;
        r_hi  <= '0;
        r_lo  <= w_mag_a;
        r_sa  <= w_sa;
        r_neg <= w_sa ^ w_sb;
        r_dz  <= w_dz;
        r_ovf <= w_ovf;
        r_cnt <= '0;
      end else if (r_state == S_CALC) begin
        if (!r_f3[2]) begin
          r_hi <= w_sum[XLEN:1];
          r_lo <= {w_sum[0], r_lo[XLEN-1:1]};
        end else begin
          r_hi <= w_ge ? w_sub[XLEN-1:0] : w_shr[XLEN-1:0];
          r_lo <= {r_lo[XLEN-2:0], w_ge};
        end
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign w_prod = r_neg ? -{r_hi, r_lo} : {r_hi, r_lo};
  assign w_quo  = r_neg ? -r_lo : r_lo;
  assign w_rem  = r_sa  ? -r_hi : r_hi;

  // Special divide cases override whatever path produced the raw registers.
  always_comb begin
    w_res = '0;
    if (r_state == S_DONE) begin
      if (!r_f3[2])
        w_res = (r_f3[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
      else if (!r_f3[1])
        w_res = r_dz ? '1 : (r_ovf ? r_a : w_quo);
      else
        w_res = r_dz ? r_a : (r_ovf ? '0 : w_rem);
    end
  end

  assign ready_o  = (r_state == S_IDLE);
  assign valid_o  = (r_state == S_DONE);
  assign busy_o   = (r_state == S_CALC) || (r_state == S_DONE);
  assign result_o = w_res;
endmodule

// File: tb/tb_riscv_muldiv.sv
// Randomized self-checking bench for riscv_muldiv (XLEN=32, EARLY_OUT=1) against
// an arithmetic reference model of the RISC-V M-extension.
module tb_riscv_muldiv;
  logic        clk = 1'b0;
  logic        rst_n, valid_i, flush_i, ready_i;
  logic        ready_o, valid_o, busy_o;
  logic [2:0]  funct3_i;
  logic [31:0] op_a_i, op_b_i, result_o;
  int total = 0;
  int bad   = 0;

  riscv_muldiv #(.XLEN(32), .EARLY_OUT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o),
    .funct3_i(funct3_i), .op_a_i(op_a_i), .op_b_i(op_b_i), .flush_i(flush_i),
    .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb;
    longint unsigned ua, ub;
    logic [63:0] p;
    int ia, ib, q;
    ia = a; ib = b; sa = ia; sb = ib; ua = a; ub = b;
    q = 0;
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        q = ia / ib; return q;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        q = ia % ib; return q;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return $urandom_range(0, 20);
      4: return -$urandom_range(1, 20);
      default: return $urandom;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input string tag);
    logic [31:0] exp;
    int lat;
    bit special;
    exp = ref_op(f, a, b);
    special = f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    chk({tag, ":rdy_in"}, ready_o, 1);
    valid_i = 1; funct3_i = f; op_a_i = a; op_b_i = b;
    tick();
    valid_i = 0; funct3_i = 3'($urandom); op_a_i = $urandom; op_b_i = $urandom;
    lat = 1;
    if (!valid_o) chk({tag, ":zero_busy"}, {busy_o, result_o}, {1'b1, 32'h0});
    while (!valid_o && lat < 100) begin
      tick();
      lat++;
    end
    chk({tag, ":lat"}, lat, special ? 1 : 33);
    chk({tag, ":res"}, result_o, exp);
    repeat (hold) begin
      tick();
      chk({tag, ":hold"}, {ready_o, valid_o, result_o}, {1'b0, 1'b1, exp});
    end
    chk({tag, ":hs_rdy"}, ready_o, 0);
    ready_i = 1;
    tick();
    ready_i = 0;
    chk({tag, ":after"}, {ready_o, valid_o, busy_o, result_o}, {3'b100, 32'h0});
  endtask

  task automatic abort_op(input bit use_rst, input int at, input string tag);
    int seen;
    valid_i = 1; funct3_i = 3'd4; op_a_i = 32'd1000; op_b_i = 32'd7;
    tick();
    valid_i = 0;
    repeat (at - 1) tick();
    if (use_rst) rst_n = 0; else flush_i = 1;
    tick();
    rst_n = 1; flush_i = 0;
    chk({tag, ":state"}, {ready_o, valid_o, busy_o, result_o}, {3'b100, 32'h0});
    seen = 0;
    repeat (40) begin
      tick();
      if (valid_o) seen++;
    end
    chk({tag, ":no_valid"}, seen, 0);
  endtask

  initial begin
    rst_n = 0; valid_i = 0; flush_i = 0; ready_i = 0;
    funct3_i = '0; op_a_i = '0; op_b_i = '0;
    repeat (3) tick();
    rst_n = 1;
    chk("reset", {ready_o, valid_o, busy_o, result_o}, {3'b100, 32'h0});

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0, "mul");
    chk("mul_ref", ref_op(3'd0, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 0, "mulh");
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhu");
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhsu");
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0, "div");
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0, "rem");
    run_op(3'd5, 32'd100, 32'd7, 0, "divu");
    run_op(3'd7, 32'd100, 32'd7, 0, "remu");
    run_op(3'd5, 32'd5, 32'd0, 0, "divu0");
    run_op(3'd7, 32'd5, 32'd0, 0, "remu0");
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0, "rem_ovf");
    run_op(3'd4, 32'hFFFF_FFF9, 32'd0, 0, "div0_neg");

    run_op(3'd0, 32'd123, 32'd456, 5, "bp");
    run_op(3'd5, 32'd99, 32'd10, 0, "b2b");

    valid_i = 1; flush_i = 1; funct3_i = 3'd0; op_a_i = 32'd3; op_b_i = 32'd3;
    tick();
    valid_i = 0; flush_i = 0;
    chk("idle_flush", {ready_o, busy_o}, 2'b10);

    abort_op(1'b0, 10, "flush");
    abort_op(1'b1, 20, "reset_mid");
    run_op(3'd0, 32'd3, 32'd4, 0, "mul_after");

    for (int i = 0; i < 40; i++)
      run_op(3'($urandom), pick(), pick(), $urandom_range(0, 2), "rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
